// File: rtl/lcd_bus_monitor_if.sv
// Bus/stream bundle for lcd_bus_monitor.
// The master side is the HD44780 driver plus the stream consumer; the slave side is the monitor.
interface lcd_bus_monitor_if;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_rs;

    modport master (
        output lcd_data, lcd_rs, lcd_rw, lcd_e, out_ready,
        input  out_valid, out_data, out_rs
    );

    modport slave (
        input  lcd_data, lcd_rs, lcd_rw, lcd_e, out_ready,
        output out_valid, out_data, out_rs
    );
endinterface

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 4-bit bus receiver: rebuilds bytes from E strobes, shadows the DDRAM
// cursor and interface width, and streams decoded bytes out through a show-ahead FIFO.
module lcd_bus_monitor #(
    parameter int MIN_E_CYCLES   = 3,
    parameter int NIBBLE_TIMEOUT = 25000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_bus_monitor_if.slave    bus,
    output logic                four_bit_mode,
    output logic [6:0]          cursor_addr,
    output logic                overflow,
    output logic                desync,
    input  logic                clear_flags
);
    localparam int EW = $clog2(MIN_E_CYCLES + 1);
    localparam int TW = $clog2(NIBBLE_TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [EW-1:0] E_MIN     = EW'(MIN_E_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(NIBBLE_TIMEOUT - 1);
    localparam logic [PW-1:0] FIFO_FULL = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        MODE8    = 2'd0,
        MODE4_HI = 2'd1,
        MODE4_LO = 2'd2
    } mode_e;

    logic [6:0]    sync1_r, sync2_r;
    logic          e_sync_s, e_prev_r, strobe_s;
    logic [EW-1:0] e_cnt_r;
    logic [3:0]    cap_data_r;
    logic          cap_rs_r, cap_rw_r;

    mode_e         state_r, state_n;
    logic [3:0]    hi_r, hi_n;
    logic          hi_rs_r, hi_rs_n;
    logic [TW-1:0] to_cnt_r, to_cnt_n;
    logic          byte_vld_s, byte_rs_s, desync_set_s;
    logic [7:0]    byte_s;

    logic [8:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic          empty_s, full_s, push_s, pop_s, ovf_set_s;
    logic [8:0]    head_s;

    // Two-stage synchronizer, packed as {e, rw, rs, data}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= {bus.lcd_e, bus.lcd_rw, bus.lcd_rs, bus.lcd_data};
            sync2_r <= sync1_r;
        end
    end

    assign e_sync_s = sync2_r[6];

    // E high-time (saturating at the qualifying length) and bus capture while E is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev_r   <= 1'b0;
            e_cnt_r    <= {EW{1'b0}};
            cap_data_r <= 4'd0;
            cap_rs_r   <= 1'b0;
            cap_rw_r   <= 1'b0;
        end else begin
            e_prev_r <= e_sync_s;
            if (e_sync_s) begin
                if (e_cnt_r != E_MIN) begin
                    e_cnt_r <= e_cnt_r + EW'(1);
                end
                cap_data_r <= sync2_r[3:0];
                cap_rs_r   <= sync2_r[4];
                cap_rw_r   <= sync2_r[5];
            end else begin
                e_cnt_r <= {EW{1'b0}};
            end
        end
    end

    assign strobe_s = e_prev_r && !e_sync_s && (e_cnt_r == E_MIN) && !cap_rw_r;

    // Nibble pairing, interface width tracking and pairing timeout
    always_comb begin
        state_n      = state_r;
        hi_n         = hi_r;
        hi_rs_n      = hi_rs_r;
        to_cnt_n     = to_cnt_r;
        byte_vld_s   = 1'b0;
        byte_s       = 8'd0;
        byte_rs_s    = 1'b0;
        desync_set_s = 1'b0;
        case (state_r)
            MODE8: begin
                if (strobe_s) begin
                    byte_vld_s = 1'b1;
                    byte_s     = {cap_data_r, 4'b0000};
                    byte_rs_s  = cap_rs_r;
                    if (!cap_rs_r && (cap_data_r == 4'h2)) begin
                        state_n = MODE4_HI;
                    end else begin
                        state_n = MODE8;
                    end
                end else begin
                    state_n = MODE8;
                end
            end
            MODE4_HI: begin
                if (strobe_s) begin
                    hi_n     = cap_data_r;
                    hi_rs_n  = cap_rs_r;
                    to_cnt_n = {TW{1'b0}};
                    state_n  = MODE4_LO;
                end else begin
                    state_n = MODE4_HI;
                end
            end
            MODE4_LO: begin
                to_cnt_n = to_cnt_r + TW'(1);
                if (strobe_s) begin
                    if (cap_rs_r == hi_rs_r) begin
                        byte_vld_s = 1'b1;
                        byte_s     = {hi_r, cap_data_r};
                        byte_rs_s  = hi_rs_r;
                        // High nibble 3 on a command is function set with DL=1
                        if (!hi_rs_r && (hi_r == 4'h3)) begin
                            state_n = MODE8;
                        end else begin
                            state_n = MODE4_HI;
                        end
                    end else begin
                        desync_set_s = 1'b1;
                        hi_n         = cap_data_r;
                        hi_rs_n      = cap_rs_r;
                        to_cnt_n     = {TW{1'b0}};
                        state_n      = MODE4_LO;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    desync_set_s = 1'b1;
                    to_cnt_n     = {TW{1'b0}};
                    state_n      = MODE4_HI;
                end else begin
                    state_n = MODE4_LO;
                end
            end
            default: begin
                state_n = MODE8;
            end
        endcase
    end

    // Pairing state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MODE8;
            hi_r     <= 4'd0;
            hi_rs_r  <= 1'b0;
            to_cnt_r <= {TW{1'b0}};
        end else begin
            state_r  <= state_n;
            hi_r     <= hi_n;
            hi_rs_r  <= hi_rs_n;
            to_cnt_r <= to_cnt_n;
        end
    end

    assign four_bit_mode = (state_r != MODE8);

    // Shadow DDRAM address; tracks every completed byte, even ones the FIFO drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_addr <= 7'd0;
        end else if (byte_vld_s) begin
            if (!byte_rs_s && ((byte_s == 8'h01) || (byte_s[7:1] == 7'b0000001))) begin
                cursor_addr <= 7'd0;
            end else if (!byte_rs_s && byte_s[7]) begin
                cursor_addr <= byte_s[6:0];
            end else if (byte_rs_s) begin
                cursor_addr <= cursor_addr + 7'd1;
            end else begin
                cursor_addr <= cursor_addr;
            end
        end
    end

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = ((wr_ptr_r - rd_ptr_r) == FIFO_FULL);
    assign pop_s     = !empty_s && bus.out_ready;
    assign push_s    = byte_vld_s && (!full_s || pop_s);
    assign ovf_set_s = byte_vld_s && full_s && !pop_s;
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

    // Show-ahead FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'd0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {byte_rs_s, byte_s};
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    assign bus.out_valid = !empty_s;
    assign bus.out_data  = head_s[7:0];
    assign bus.out_rs    = head_s[8];

    // Sticky error flags; a set event overrides a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            desync   <= 1'b0;
        end else begin
            overflow <= ovf_set_s    | (overflow & !clear_flags);
            desync   <= desync_set_s | (desync   & !clear_flags);
        end
    end
endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Passive receiver on the HD44780 4-bit parallel bus (lcd_data/lcd_rs/lcd_rw/lcd_e), i.e. the display-side end of the interface that lcd_controller drives.
- Reassembles nibble strobes into bytes, tracks 8-bit/4-bit interface mode and the DDRAM cursor address, and presents bytes on a valid/ready stream through a small FIFO.
- Used for on-FPGA loopback self-test: controller outputs are fed back into this monitor, and its stream is forwarded to uart_tx for debug.

Parameters:
- MIN_E_CYCLES, 3: minimum synchronized high cycles of E for a strobe to count.
- NIBBLE_TIMEOUT, 25000: cycles allowed between high and low nibble (1 ms at 25 MHz).
- FIFO_DEPTH, 4: output FIFO entries (power of two).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_data  in  4  bus data nibble (DB7..DB4)
- lcd_rs  in  1  register select (0 = command, 1 = data)
- lcd_rw  in  1  1 = read cycle
- lcd_e  in  1  enable strobe
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid=1
- out_data  out  8  decoded byte
- out_rs  out  1  rs of decoded byte
- four_bit_mode  out  1  1 = nibble-pair mode active
- cursor_addr  out  7  shadow DDRAM address counter
- overflow  out  1  sticky: byte dropped because FIFO full
- desync  out  1  sticky: nibble pairing lost
- clear_flags  in  1  clears overflow and desync

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; mode = MODE8; FIFO empty; timers 0. Reset mid-byte discards any partial nibble.
- Synchronization: 2-FF synchronizer on all 7 bus inputs.
  - E high counter increments while e_sync=1.
  - Falling edge detected in the cycle e_sync=0 and the previous e_sync=1.
  - Data, rs and rw are taken from their synchronized values in the last cycle e_sync was 1.
- Strobe qualification: an edge is ignored (no state change) if the high count < MIN_E_CYCLES or captured rw=1.
- State machine:
  - MODE8: each strobe yields byte {nibble,4'b0000} with its rs. If rs=0 and nibble=4'h2, go to MODE4_HI and set four_bit_mode.
  - MODE4_HI: a strobe stores the high nibble and rs, clears the timeout counter, and goes to MODE4_LO.
  - MODE4_LO:
    - Counter increments every cycle.
    - A strobe with the same rs yields byte {hi,lo} and returns to MODE4_HI.
    - A strobe with a different rs sets desync, stores the strobe as a new high nibble, and stays in MODE4_LO with the counter cleared.
    - If the counter reaches NIBBLE_TIMEOUT: set desync, drop the high nibble, go to MODE4_HI.
  - Any 4-bit-mode command with [7:5]=3'b001 and bit4=1 (function set DL=1): after emitting, go to MODE8 and clear four_bit_mode.
- Cursor update, applied on every completed byte, including those dropped by a full FIFO:
  - rs=0, byte=0x01, or byte[7:1]=7'b0000001: cursor_addr = 0.
  - rs=0, byte[7]=1: cursor_addr = byte[6:0].
  - rs=1: cursor_addr = cursor_addr + 1, wrapping 0x7F -> 0x00.
  - Cursor is updated in the cycle after edge detection (N+1).
- FIFO (show-ahead):
  - Completed byte written at N+1; out_valid high no later than N+2 when the FIFO was empty.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full and no pop: byte dropped, overflow set.
- Sticky flags: clear_flags clears overflow and desync. If a set event and clear_flags occur in the same cycle, set wins.

Test Plan:
1. Reset, then rs=0 strobes with nibbles 3,3,3,2 (E high 10 cycles), out_ready=1 -> outputs 0x30,0x30,0x30,0x20 with rs=0; four_bit_mode=1 after the 4th strobe.
2. In 4-bit mode, pairs (0,1) rs=0, (4,8) rs=1, (5,7) rs=1 -> 0x01/rs0 with cursor 0, then 0x48/rs1 with cursor 1, then 0x57/rs1 with cursor 2.
3. Command 0xFF sets cursor 0x7F; then data 0x41 -> cursor 0x00. Command 0xC0 -> cursor 0x40.
4. High nibble 4 (rs=1), idle 30000 cycles -> desync=1, no output. Next pair (4,8) -> 0x48. clear_flags pulse -> desync=0.
5. out_ready=0, send bytes 0x41..0x45 -> overflow=1, cursor advanced 5. Raise out_ready -> 0x41..0x44 drained in order, out_valid falls.
6. E pulse of 2 cycles -> ignored. Strobe with rw=1 -> ignored. rst_n low between nibbles -> all outputs 0, mode MODE8, FIFO empty.
